jk_input_debounce: RTL and testbench

JK_INPUT_DEBOUNCE -- requirements
Module: jk_input_debounce

---
 rtl/jk_input_debounce.sv | 190 +++++++++++++++++++
 tb/tb_jk_input_debounce.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_input_debounce.sv
// jk_input_debounce
//   Debounces the two bouncing switch inputs (J and K) that feed a JK
//   flip-flop. Each raw input first passes through a 2-flop synchronizer.
//   A free-running divider then produces a sample tick every DIV clocks.
//   Each channel runs a four-state FSM that accepts a new level only after
//   STABLE_N consecutive tick samples agree with it.
//
// Parameters
//   DIV       iClk cycles per sample tick (>= 2)
//   STABLE_N  consecutive agreeing ticks needed to accept a level (>= 2)
//
// Ports
//   iClk    in   system clock, rising edge
//   iReset  in   synchronous active-high reset
//   iJ_raw  in   raw J switch (asynchronous, bouncing)
//   iK_raw  in   raw K switch (asynchronous, bouncing)
//   oJ      out  debounced J, registered
//   oK      out  debounced K, registered
//   oTick   out  one-cycle sample-tick pulse (divider at DIV-1)
//   oBusy   out  only when DEBOUNCE_STATUS_EN is defined: registered,
//                high while either channel is in RISE_WAIT or FALL_WAIT
//
// Configuration macro: DEBOUNCE_STATUS_EN (adds oBusy)
//
// Per-channel state (state_q / cnt_q, index 0 = J, 1 = K) is kept in plain
// arrays so it can be probed hierarchically.
module jk_input_debounce #(
  parameter int DIV      = 10,
  parameter int STABLE_N = 4
) (
  input  logic iClk,
  input  logic iReset,
  input  logic iJ_raw,
  input  logic iK_raw,
  output logic oJ,
  output logic oK,
`ifdef DEBOUNCE_STATUS_EN
  output logic oBusy,
`endif
  output logic oTick
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNT_W = (STABLE_N > 1) ? $clog2(STABLE_N) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_N - 1);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_WAIT = 2'd1,
    HIGH      = 2'd2,
    FALL_WAIT = 2'd3
  } db_state_t;

  // Two-flop synchronizers; bit 0 = J, bit 1 = K.
  logic [1:0] sync1_q;
  logic [1:0] sync2_q;

  always_ff @(posedge iClk) begin
    if (iReset) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {iK_raw, iJ_raw};
      sync2_q <= sync1_q;
    end
  end

  // Sample-tick divider.
  logic [DIV_W-1:0] div_q;
  logic             tick;

  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge iClk) begin
    if (iReset) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Gated so the pulse is low even in the very first reset cycle.
  assign oTick = tick & ~iReset;

  // Per-channel debounce FSMs.
  db_state_t        state_q [2];
  db_state_t        state_d [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];
  logic [1:0]       level_d;
  logic [1:0]       out_q;
  logic             busy_d;

  always_comb begin
    busy_d  = 1'b0;
    level_d = 2'b00;
    for (int ch = 0; ch < 2; ch++) begin
      state_d[ch] = state_q[ch];
      cnt_d[ch]   = cnt_q[ch];
      if (tick) begin
        case (state_q[ch])
          LOW: begin
            if (sync2_q[ch]) begin
              state_d[ch] = RISE_WAIT;
              cnt_d[ch]   = CNT_W'(1);
            end
          end
          RISE_WAIT: begin
            if (!sync2_q[ch]) begin
              state_d[ch] = LOW;
              cnt_d[ch]   = '0;
            end else if (cnt_q[ch] == CNT_LAST) begin
              state_d[ch] = HIGH;
              cnt_d[ch]   = '0;
            end else begin
              cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
            end
          end
          HIGH: begin
            if (!sync2_q[ch]) begin
              state_d[ch] = FALL_WAIT;
              cnt_d[ch]   = CNT_W'(1);
            end
          end
          FALL_WAIT: begin
            if (sync2_q[ch]) begin
              state_d[ch] = HIGH;
              cnt_d[ch]   = '0;
            end else if (cnt_q[ch] == CNT_LAST) begin
              state_d[ch] = LOW;
              cnt_d[ch]   = '0;
            end else begin
              cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
            end
          end
          default: begin
            state_d[ch] = LOW;
            cnt_d[ch]   = '0;
          end
        endcase
      end
      // Output follows the next state so it updates with the state register.
      level_d[ch] = (state_d[ch] == HIGH) || (state_d[ch] == FALL_WAIT);
      if ((state_d[ch] == RISE_WAIT) || (state_d[ch] == FALL_WAIT)) begin
        busy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch] <= LOW;
        cnt_q[ch]   <= '0;
      end
      out_q <= 2'b00;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch] <= state_d[ch];
        cnt_q[ch]   <= cnt_d[ch];
      end
      out_q <= level_d;
    end
  end

  assign oJ = out_q[0];
  assign oK = out_q[1];

`ifdef DEBOUNCE_STATUS_EN
  logic busy_q;

  always_ff @(posedge iClk) begin
    if (iReset) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign oBusy = busy_q;
`else
  // busy_d only has a consumer when the status output is built in.
  logic busy_unused;
  assign busy_unused = busy_d;
`endif

endmodule

// File: tb/tb_jk_input_debounce.sv
// tb_jk_input_debounce
//   Randomized and directed stimulus for jk_input_debounce (DIV=10,
//   STABLE_N=4). The reference model keeps a history of tick samples per
//   channel and flips a channel's output once the last STABLE_N samples all
//   disagree with it. Expected outputs go through exp_q and are compared
//   one cycle at a time. Inputs change 1 time unit after each rising edge,
//   and outputs are sampled at that same point.
module tb_jk_input_debounce;

  localparam int DIV      = 10;
  localparam int STABLE_N = 4;
  localparam int LAT_MIN  = 2 + (STABLE_N - 1) * DIV + 1;
  localparam int LAT_MAX  = 2 + STABLE_N * DIV;

  logic iClk;
  logic iReset;
  logic iJ_raw;
  logic iK_raw;
  logic oJ;
  logic oK;
  logic oTick;
`ifdef DEBOUNCE_STATUS_EN
  logic oBusy;
`endif

  jk_input_debounce #(.DIV(DIV), .STABLE_N(STABLE_N)) dut (
    .iClk   (iClk),
    .iReset (iReset),
    .iJ_raw (iJ_raw),
    .iK_raw (iK_raw),
    .oJ     (oJ),
    .oK     (oK),
`ifdef DEBOUNCE_STATUS_EN
    .oBusy  (oBusy),
`endif
    .oTick  (oTick)
  );

  // Clock / reset
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Scoreboard state
  int n_vec = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];   // {busy, tick, k, j}

  // Reference model state
  bit m_sj1, m_sj2, m_sk1, m_sk2;
  int m_div;
  bit m_out_j, m_out_k;
  bit m_busy;
  bit m_hist_j[$];
  bit m_hist_k[$];

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Length of the run of value v at the tail of the history.
  function automatic int trail_run(input bit q[$], input bit v);
    int n = 0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i] != v) break;
      n++;
    end
    return n;
  endfunction

  // Advance the model across one rising edge using the inputs applied now.
  task automatic model_step();
    bit tk;
    bit last_j, last_k;
    if (iReset) begin
      m_sj1 = 0; m_sj2 = 0; m_sk1 = 0; m_sk2 = 0;
      m_div = 0;
      m_out_j = 0; m_out_k = 0;
      m_hist_j.delete();
      m_hist_k.delete();
    end else begin
      tk = (m_div == DIV - 1);
      if (tk) begin
        m_hist_j.push_back(m_sj2);
        m_hist_k.push_back(m_sk2);
        if (m_hist_j.size() > STABLE_N) void'(m_hist_j.pop_front());
        if (m_hist_k.size() > STABLE_N) void'(m_hist_k.pop_front());
        if (trail_run(m_hist_j, !m_out_j) >= STABLE_N) m_out_j = !m_out_j;
        if (trail_run(m_hist_k, !m_out_k) >= STABLE_N) m_out_k = !m_out_k;
      end
      m_div = tk ? 0 : m_div + 1;
      m_sj2 = m_sj1; m_sj1 = iJ_raw;
      m_sk2 = m_sk1; m_sk1 = iK_raw;
    end
    // A channel is waiting whenever its latest sample disagrees with its output.
    last_j = (m_hist_j.size() > 0) ? m_hist_j[m_hist_j.size() - 1] : 1'b0;
    last_k = (m_hist_k.size() > 0) ? m_hist_k[m_hist_k.size() - 1] : 1'b0;
    m_busy = (last_j != m_out_j) || (last_k != m_out_k);
    exp_q.push_back({m_busy, (m_div == DIV - 1) && !iReset, m_out_k, m_out_j});
  endtask

  // One clock: predict, let the edge pass, compare.
  task automatic step();
    logic [3:0] e;
    model_step();
    @(posedge iClk);
    #1;
    e = exp_q.pop_front();
    check_eq("oJ", oJ, e[0]);
    check_eq("oK", oK, e[1]);
    check_eq("oTick", oTick, e[2]);
`ifdef DEBOUNCE_STATUS_EN
    check_eq("oBusy", oBusy, e[3]);
`endif
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int n;
    bit k_seen;
    bit busy_seen;

    iReset = 1'b1;
    iJ_raw = 1'b0;
    iK_raw = 1'b0;

    // Reset held 17 cycles with raw inputs toggling.
    for (int i = 0; i < 17; i++) begin
      iJ_raw = 1'($urandom);
      iK_raw = 1'($urandom);
      step();
      check_eq("reset_outputs_zero", {oJ, oK, oTick}, 3'b000);
    end

    // Release: first tick lands in the DIV-th cycle with iReset=0.
    iReset = 1'b0;
    iJ_raw = 1'b0;
    iK_raw = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (oTick !== 1'b1 && n < 100);
    check_eq("first_tick_cycle", n + 1, DIV);
    run(7);

    // Clean J rise, latency window, K unaffected.
    iJ_raw = 1'b1;
    n = 0;
    busy_seen = 1'b0;
    do begin
      step();
      n++;
    end while (oJ !== 1'b1 && n < 100);
    check_eq("j_rise_in_window", (n >= LAT_MIN && n <= LAT_MAX), 1);
    check_eq("k_idle_during_j", oK, 1'b0);
    run(25);
    check_eq("j_held_high", oJ, 1'b1);

    // Clean J fall.
    iJ_raw = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (oJ !== 1'b0 && n < 100);
    check_eq("j_fall_in_window", (n >= LAT_MIN && n <= LAT_MAX), 1);
    run(13);

    // 15-cycle K glitch is rejected.
    k_seen = 1'b0;
    iK_raw = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      k_seen |= oK;
    end
    iK_raw = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      k_seen |= oK;
    end
    check_eq("k_pulse_rejected", k_seen, 1'b0);

    // Simultaneous J/K rise and fall land on one edge.
    iJ_raw = 1'b1;
    iK_raw = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (oJ !== 1'b1 && oK !== 1'b1 && n < 100);
    check_eq("jk_rise_same_edge", {oJ, oK}, 2'b11);
    run(17);
    iJ_raw = 1'b0;
    iK_raw = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (oJ !== 1'b0 && oK !== 1'b0 && n < 100);
    check_eq("jk_fall_same_edge", {oJ, oK}, 2'b00);
    run(23);

    // Reset while J is two ticks into its rise qualification.
    iJ_raw = 1'b1;
    n = 0;
    while (!(m_out_j == 1'b0 && trail_run(m_hist_j, 1'b1) == 2) && n < 100) begin
      step();
      n++;
    end
    check_eq("reached_rise_wait_cnt2", n < 100, 1);
    iReset = 1'b1;
    step();
    check_eq("j_zero_in_reset", oJ, 1'b0);
    iReset = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (oJ !== 1'b1 && n < 200);
    check_eq("j_requalify_cycles", n, STABLE_N * DIV);
    run(11);

    // Randomized segments: long holds, bounce bursts, occasional reset.
    for (int seg = 0; seg < 45; seg++) begin
      int mode;
      int len;
      mode = $urandom_range(0, 9);
      if (mode == 0) begin
        iReset = 1'b1;
        run($urandom_range(1, 3));
        iReset = 1'b0;
      end else if (mode < 5) begin
        iJ_raw = 1'($urandom);
        iK_raw = 1'($urandom);
        run($urandom_range(30, 80));
      end else begin
        len = $urandom_range(5, 40);
        for (int i = 0; i < len; i++) begin
          if ($urandom_range(0, 2) == 0) iJ_raw = ~iJ_raw;
          if ($urandom_range(0, 2) == 0) iK_raw = ~iK_raw;
          step();
        end
      end
    end

`ifdef DEBOUNCE_STATUS_EN
    // Busy spans exactly the rise qualification of a clean J edge.
    iReset = 1'b1;
    iJ_raw = 1'b0;
    iK_raw = 1'b0;
    run(2);
    iReset = 1'b0;
    run(5);
    iJ_raw = 1'b1;
    n = 0;
    do begin
      step();
      n++;
      busy_seen |= oBusy;
    end while (oJ !== 1'b1 && n < 100);
    check_eq("busy_seen_before_rise", busy_seen, 1'b1);
    check_eq("busy_low_at_rise", oBusy, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
